// File: rtl/unit_handshake_pkg.sv
// unit_handshake_pkg: shared FSM state type and width helper for the handshake pipe
package unit_handshake_pkg;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic int min1_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/handshake_fifo.sv
// handshake_fifo: DEPTH-entry result queue with flush and explicit pointer wrap
import unit_handshake_pkg::*;
module handshake_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = min1_clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head_data = mem[rd_ptr];
  // pointers and occupancy; flush empties the queue without touching storage
  always_ff @(posedge clk or posedge reset)
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  // result storage needs no reset; occupancy decides what is visible
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/unit_handshake_pipe.sv
// unit_handshake_pipe: ready/valid wrapper launching a multicycle unit and queueing its results
import unit_handshake_pkg::*;
module unit_handshake_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       unit_start,
  output logic [WIDTH-1:0]           unit_operand,
  input  logic [WIDTH-1:0]           unit_result,
  input  logic                       unit_done,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CNW = min1_clog2(LATENCY+1);
  state_t state, state_next;
  logic [CNW-1:0] lat_cnt;
  logic accept, capture, full, empty;
  assign in_ready = state == IDLE && !full && !flush;
  assign accept = in_valid && in_ready;
  assign capture = state == BUSY && ((LATENCY == 0) ? unit_done : lat_cnt == CNW'(LATENCY-1));
  assign busy = state == BUSY;
  assign out_valid = !empty;
  // next state: flush wins, then accept from IDLE, then capture from BUSY
  always_comb state_next = flush ? IDLE : accept ? BUSY : capture ? IDLE : state;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_next;
  // operand capture, one-cycle start pulse and latency counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      unit_start <= 1'b0;
      unit_operand <= '0;
      lat_cnt <= '0;
    end else begin
      unit_start <= accept;
      if (accept) unit_operand <= in_data;
      lat_cnt <= (flush || accept || capture || LATENCY == 0) ? '0 : busy ? lat_cnt + 1'b1 : lat_cnt;
    end
  handshake_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(capture && !flush),
    .pop(out_valid && out_ready),
    .flush(flush),
    .push_data(unit_result),
    .head_data(out_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule
